// File: rtl/aes_stream_ctrl_pkg.sv
// Shared AES stream controller constants, command codes, FSM states and mode payload.
package aes_stream_ctrl_pkg;

  localparam int unsigned KEY_S         = 128;
  localparam int unsigned BLK_S         = 128;
  localparam int unsigned WORD_S        = 32;
  localparam int unsigned WORDS_PER_BLK = BLK_S / WORD_S;
  localparam int unsigned CNT_W         = $clog2(WORDS_PER_BLK);
  localparam int unsigned WORD_LSB      = $clog2(WORD_S);
  localparam int unsigned IDX_W         = $clog2(BLK_S);

  localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(WORDS_PER_BLK - 1);

  localparam logic [WORD_S-1:0] CMD_KEY_EXP = WORD_S'(32'h0000_0001);
  localparam logic [WORD_S-1:0] CMD_ENCRYPT = WORD_S'(32'h0000_0002);
  localparam logic [WORD_S-1:0] CMD_DECRYPT = WORD_S'(32'h0000_0004);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_SEND,
    ST_DRAIN
  } state_t;

  // One-hot operation select presented to the AES core.
  typedef struct packed {
    logic key_exp;
    logic cipher;
    logic decipher;
  } mode_t;

  // Command word to mode; all-zero result marks an invalid command.
  function automatic mode_t cmd_decode(input logic [WORD_S-1:0] cmd);
    mode_t m;
    m = '0;
    case (cmd)
      CMD_KEY_EXP: m.key_exp  = 1'b1;
      CMD_ENCRYPT: m.cipher   = 1'b1;
      CMD_DECRYPT: m.decipher = 1'b1;
      default:     m          = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/aes_stream_ctrl_if.sv
// 32-bit AXI-stream style handshake bundle.
//   tdata/tvalid/tlast : driven by master
//   tready             : driven by slave
interface aes_stream_ctrl_if;
  import aes_stream_ctrl_pkg::*;

  logic [WORD_S-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aes_word_serializer.sv
// Captures a 128-bit block and emits it as four 32-bit stream beats, MSB word first.
//   clk, reset : clock, async active-high reset
//   load       : capture blk and start emitting
//   blk        : block to send (bit 0 = MSB)
//   tdata/tvalid/tlast/tready : output stream
//   done_c     : last beat accepted this cycle
module aes_word_serializer
  import aes_stream_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [0:BLK_S-1]  blk,
  output logic [WORD_S-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  input  logic              tready,
  output logic              done_c
);

  logic [0:BLK_S-1] out_reg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] nxt_lo;

  // Next word index and its bit offset inside the output register.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    nxt_lo  = {cnt_nxt, {WORD_LSB{1'b0}}};
    done_c  = tvalid && tready && tlast;
  end

  // Output register and beat sequencing; tdata/tlast only move on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= '0;
      cnt     <= '0;
      tdata   <= '0;
      tvalid  <= 1'b0;
      tlast   <= 1'b0;
    end else if (load) begin
      out_reg <= blk;
      cnt     <= '0;
      tdata   <= blk[0 +: WORD_S];
      tvalid  <= 1'b1;
      tlast   <= 1'b0;
    end else if (tvalid && tready) begin
      if (tlast) begin
        cnt    <= '0;
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end else begin
        cnt   <= cnt_nxt;
        tdata <= out_reg[nxt_lo +: WORD_S];
        tlast <= (cnt_nxt == LAST_CNT);
      end
    end
  end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Packet controller between an AXI-stream command/data port and an AES core.
// A packet is a command word plus four payload words (tlast on the fourth);
// key expansion loads aes_key, encrypt/decrypt load aes_in_blk and return
// the core result as four output beats.
//   clk, reset  : clock, async active-high reset
//   s_axis      : command/data input stream (slave)
//   m_axis      : result output stream (master)
//   en          : one-cycle start strobe to the core
//   cipher_mode, decipher_mode, key_exp_mode : one-hot operation select
//   aes_key, aes_in_blk : key and block registers (bit 0 = MSB)
//   aes_out_blk, en_o   : core result and completion pulse
module aes_stream_ctrl
  import aes_stream_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  aes_stream_ctrl_if.slave  s_axis,
  aes_stream_ctrl_if.master m_axis,
  output logic             en,
  output logic             cipher_mode,
  output logic             decipher_mode,
  output logic             key_exp_mode,
  output logic [0:KEY_S-1] aes_key,
  output logic [0:BLK_S-1] aes_in_blk,
  input  logic [0:BLK_S-1] aes_out_blk,
  input  logic             en_o
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mode_t            mode, mode_nxt;
  logic [0:KEY_S-1] key_nxt;
  logic [0:BLK_S-1] blk_nxt;
  logic [IDX_W-1:0] slice_lo;
  logic             s_tready;
  logic             s_fire_c;
  logic             ser_load_c;
  logic             ser_done_c;

  assign s_fire_c      = s_axis.tvalid && s_tready;
  assign s_axis.tready = s_tready;
  assign key_exp_mode  = mode.key_exp;
  assign cipher_mode   = mode.cipher;
  assign decipher_mode = mode.decipher;

  // Next-state, load and mode decisions.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mode_nxt   = mode;
    key_nxt    = aes_key;
    blk_nxt    = aes_in_blk;
    ser_load_c = 1'b0;
    slice_lo   = {cnt, {WORD_LSB{1'b0}}};

    case (state)
      ST_IDLE: begin
        // A command beat carrying tlast is a truncated packet and is dropped.
        if (s_fire_c && !s_axis.tlast) begin
          mode_nxt  = cmd_decode(s_axis.tdata);
          cnt_nxt   = '0;
          state_nxt = (|mode_nxt) ? ST_LOAD : ST_DRAIN;
        end
      end
      ST_LOAD: begin
        if (s_fire_c) begin
          if (mode.key_exp) key_nxt[slice_lo +: WORD_S] = s_axis.tdata;
          else              blk_nxt[slice_lo +: WORD_S] = s_axis.tdata;
          if (cnt == LAST_CNT) begin
            cnt_nxt = '0;
            if (s_axis.tlast) begin
              state_nxt = ST_START;
            end else begin
              state_nxt = ST_DRAIN;
              mode_nxt  = '0;
            end
          end else if (s_axis.tlast) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
            mode_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (en_o) begin
          mode_nxt = '0;
          if (mode.key_exp) begin
            state_nxt = ST_IDLE;
          end else begin
            ser_load_c = 1'b1;
            state_nxt  = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (ser_done_c) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (s_fire_c && s_axis.tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; en and tready follow the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mode       <= '0;
      en         <= 1'b0;
      s_tready   <= 1'b0;
      aes_key    <= '0;
      aes_in_blk <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mode       <= mode_nxt;
      en         <= (state_nxt == ST_START);
      s_tready   <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD) ||
                    (state_nxt == ST_DRAIN);
      aes_key    <= key_nxt;
      aes_in_blk <= blk_nxt;
    end
  end

  aes_word_serializer u_ser (
    .clk    (clk),
    .reset  (reset),
    .load   (ser_load_c),
    .blk    (aes_out_blk),
    .tdata  (m_axis.tdata),
    .tvalid (m_axis.tvalid),
    .tlast  (m_axis.tlast),
    .tready (m_axis.tready),
    .done_c (ser_done_c)
  );

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Self-checking bench for aes_stream_ctrl with a stand-in AES core.
module tb_aes_stream_ctrl;
  import aes_stream_ctrl_pkg::*;

  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_stream_ctrl_if s_axis ();
  aes_stream_ctrl_if m_axis ();

  logic         en, cipher_mode, decipher_mode, key_exp_mode, en_o;
  logic [0:127] aes_key, aes_in_blk, aes_out_blk;

  aes_stream_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis        (s_axis),
    .m_axis        (m_axis),
    .en            (en),
    .cipher_mode   (cipher_mode),
    .decipher_mode (decipher_mode),
    .key_exp_mode  (key_exp_mode),
    .aes_key       (aes_key),
    .aes_in_blk    (aes_in_blk),
    .aes_out_blk   (aes_out_blk),
    .en_o          (en_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in AES core: real FIPS-197 vectors for the known key, otherwise a simple mix.
  function automatic logic [127:0] core_fn(input logic [2:0] md, input logic [127:0] k,
                                           input logic [127:0] b);
    if (md == 3'b010 && k == K && b == PT) return CT;
    if (md == 3'b001 && k == K && b == CT) return PT;
    if (md == 3'b010) return b ^ k;
    if (md == 3'b001) return {b[63:0], b[127:64]} ^ k;
    return '1;
  endfunction

  bit           core_auto = 1'b1;
  bit           core_pend;
  int           core_wait;
  int           en_cnt = 0;
  logic         en_prev;
  logic [2:0]   snap_mode;
  logic [127:0] snap_key, snap_blk;

  always @(negedge clk) begin
    if (reset) begin
      core_pend = 1'b0;
      en_prev   = 1'b0;
      if (core_auto) en_o = 1'b0;
    end else begin
      if (en) begin
        en_cnt++;
        chk("en_single_cycle", en_prev, 1'b0);
        chk("mode_onehot_at_en", $countones({key_exp_mode, cipher_mode, decipher_mode}), 1);
        snap_mode = {key_exp_mode, cipher_mode, decipher_mode};
        snap_key  = aes_key;
        snap_blk  = aes_in_blk;
        core_pend = 1'b1;
        core_wait = $urandom_range(0, 4);
      end else if (core_auto) begin
        if (en_o) en_o = 1'b0;
        else if (core_pend) begin
          if (core_wait == 0) begin
            en_o        = 1'b1;
            aes_out_blk = core_fn(snap_mode, snap_key, snap_blk);
            core_pend   = 1'b0;
          end else core_wait--;
        end
      end
      en_prev = en;
    end
  end

  // Output sink: drives tready, records accepted beats, checks hold under stall.
  bit          stall_en = 1'b0;
  logic [31:0] rx_q[$];
  logic        rx_last_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;

  always @(negedge clk) begin
    m_axis.tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall)
        chk("send_hold_while_stalled", {m_axis.tvalid, m_axis.tlast, m_axis.tdata},
            {1'b1, prev_l, prev_d});
      if (m_axis.tvalid && m_axis.tready) begin
        rx_q.push_back(m_axis.tdata);
        rx_last_q.push_back(m_axis.tlast);
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_d     = m_axis.tdata;
      prev_l     = m_axis.tlast;
    end
  end

  bit          gaps = 1'b0;
  logic [31:0] seq_w[16];

  // One input beat, called just after a falling edge; returns just after the next one.
  task automatic beat(input logic [31:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_axis.tvalid = 1'b0;
      @(negedge clk);
    end
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (s_axis.tready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    chk("s_beat_accepted", ok, 1'b1);
  endtask

  task automatic send_words(input int n, input int last_at);
    for (int i = 0; i < n; i++) beat(seq_w[i], (i == last_at));
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] cmd, input logic [127:0] data);
    seq_w[0] = cmd;
    for (int i = 0; i < 4; i++) seq_w[1+i] = data[127-32*i -: 32];
    send_words(5, 4);
  endtask

  // Collect the output beats of one packet and compare against the expected block.
  task automatic expect_out(input string name, input int nexp, input logic [127:0] exp_blk);
    if (nexp == 0) begin
      repeat (25) @(negedge clk);
      chk({name, "_no_beats"}, rx_q.size(), 0);
    end else begin
      for (int i = 0; i < 300 && rx_q.size() < 4; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk({name, "_beat_count"}, rx_q.size(), 4);
      for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
        chk($sformatf("%s_word%0d", name, i), rx_q[i], exp_blk[127-32*i -: 32]);
        chk($sformatf("%s_last%0d", name, i), rx_last_q[i], (i == 3));
      end
    end
    chk({name, "_idle_modes"}, {key_exp_mode, cipher_mode, decipher_mode}, 3'b000);
    chk({name, "_idle_tready"}, s_axis.tready, 1'b1);
    rx_q.delete();
    rx_last_q.delete();
  endtask

  typedef struct {
    logic [31:0]  cmd;
    logic [127:0] data;
    int           n_en;
    int           n_beats;
    logic [127:0] exp_out;
    logic [2:0]   exp_mode;
  } vec_t;

  vec_t         vt[5];
  logic [127:0] model_key;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int           en0;
    logic [127:0] d;
    int           op;

    reset         = 1'b1;
    en_o          = 1'b0;
    aes_out_blk   = '0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;

    vt[0] = '{32'h1, K,  1, 0, 128'h0, 3'b100};
    vt[1] = '{32'h2, PT, 1, 4, CT,     3'b010};
    vt[2] = '{32'h4, CT, 1, 4, PT,     3'b001};
    vt[3] = '{32'h8, PT, 0, 0, 128'h0, 3'b000};
    vt[4] = '{32'h2, PT, 1, 4, CT,     3'b010};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_s_tready", s_axis.tready, 1'b0);
    chk("rst_m_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_m_tlast", m_axis.tlast, 1'b0);
    chk("rst_en", en, 1'b0);
    chk("rst_modes", {key_exp_mode, cipher_mode, decipher_mode}, 3'b000);
    chk("rst_aes_key", aes_key, 128'h0);
    chk("rst_aes_in_blk", aes_in_blk, 128'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", s_axis.tready, 1'b1);

    // Known-answer table: key expansion, encrypt, decrypt, invalid, encrypt again.
    model_key = '0;
    for (int v = 0; v < 5; v++) begin
      en0 = en_cnt;
      send_pkt(vt[v].cmd, vt[v].data);
      expect_out($sformatf("vec%0d", v), vt[v].n_beats, vt[v].exp_out);
      chk($sformatf("vec%0d_en_count", v), en_cnt - en0, vt[v].n_en);
      if (vt[v].n_en != 0) begin
        chk($sformatf("vec%0d_mode", v), snap_mode, vt[v].exp_mode);
        if (vt[v].exp_mode == 3'b100) begin
          model_key = vt[v].data;
          chk($sformatf("vec%0d_key_at_en", v), snap_key, vt[v].data);
        end else begin
          chk($sformatf("vec%0d_key_at_en", v), snap_key, model_key);
          chk($sformatf("vec%0d_blk_at_en", v), snap_blk, vt[v].data);
        end
      end
    end

    // Command beat carrying tlast is dropped.
    en0      = en_cnt;
    seq_w[0] = 32'h2;
    send_words(1, 0);
    expect_out("cmd_tlast", 0, 128'h0);
    chk("cmd_tlast_no_en", en_cnt - en0, 0);

    // tlast on payload word 2 aborts; mode visible mid-load then cleared.
    en0 = en_cnt;
    beat(32'h4, 1'b0);
    chk("load_decipher_mode", {key_exp_mode, cipher_mode, decipher_mode}, 3'b001);
    beat(32'hdead_beef, 1'b0);
    beat(32'hcafe_f00d, 1'b1);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    expect_out("early_tlast", 0, 128'h0);
    chk("early_tlast_no_en", en_cnt - en0, 0);

    // Word 4 without tlast drains up to the next tlast.
    en0      = en_cnt;
    seq_w[0] = 32'h2;
    for (int i = 1; i < 7; i++) seq_w[i] = 32'h1111_0000 + 32'(i);
    send_words(7, 6);
    expect_out("late_tlast", 0, 128'h0);
    chk("late_tlast_no_en", en_cnt - en0, 0);

    // Invalid command 3 with six payload words, then a good packet.
    en0      = en_cnt;
    seq_w[0] = 32'h3;
    for (int i = 1; i < 7; i++) seq_w[i] = 32'h2222_0000 + 32'(i);
    send_words(7, 6);
    expect_out("bad_cmd3", 0, 128'h0);
    chk("bad_cmd3_no_en", en_cnt - en0, 0);
    send_pkt(32'h2, PT);
    expect_out("after_cmd3", 4, CT);

    // Output back-pressure.
    stall_en = 1'b1;
    send_pkt(32'h4, CT);
    expect_out("stall_dec", 4, PT);

    // Randomised packets against the reference key/block model.
    gaps = 1'b1;
    for (int r = 0; r < 24; r++) begin
      op  = $urandom_range(0, 3);
      d   = {$urandom, $urandom, $urandom, $urandom};
      en0 = en_cnt;
      if (op == 0) begin
        send_pkt(32'h1, d);
        expect_out($sformatf("rnd%0d_kexp", r), 0, 128'h0);
        model_key = d;
      end else if (op == 3) begin
        send_pkt(32'h4, d);
        expect_out($sformatf("rnd%0d_dec", r), 4, {d[63:0], d[127:64]} ^ model_key);
      end else begin
        send_pkt(32'h2, d);
        expect_out($sformatf("rnd%0d_enc", r), 4, d ^ model_key);
      end
      chk($sformatf("rnd%0d_en_count", r), en_cnt - en0, 1);
    end
    gaps     = 1'b0;
    stall_en = 1'b0;

    // Reset while waiting on the core, then a stray completion pulse.
    core_auto = 1'b0;
    en_o      = 1'b0;
    en0       = en_cnt;
    send_pkt(32'h2, PT);
    for (int i = 0; i < 50 && en_cnt == en0; i++) @(negedge clk);
    chk("wait_rst_en_seen", en_cnt - en0, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("wait_rst_tready", s_axis.tready, 1'b0);
    chk("wait_rst_modes", {key_exp_mode, cipher_mode, decipher_mode}, 3'b000);
    chk("wait_rst_key", aes_key, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    en_o        = 1'b1;
    aes_out_blk = CT;
    @(negedge clk);
    en_o = 1'b0;
    repeat (20) @(negedge clk);
    chk("wait_rst_no_beats", rx_q.size(), 0);
    chk("wait_rst_modes_after", {key_exp_mode, cipher_mode, decipher_mode}, 3'b000);
    chk("wait_rst_tready_after", s_axis.tready, 1'b1);
    chk("wait_rst_no_new_en", en_cnt - en0, 1);
    core_auto = 1'b1;

    // Recovery: reload the key and encrypt the known block.
    send_pkt(32'h1, K);
    expect_out("recover_kexp", 0, 128'h0);
    send_pkt(32'h2, PT);
    expect_out("recover_enc", 4, CT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
